alu_response_checker: RTL and testbench

//   Receive side of the ALU test interface: accepts ALU result vectors, checks them,
//   and reports the outcome.

---
 rtl/alu_response_checker.sv | 113 +++++++++++
 tb/tb_alu_response_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_response_checker.sv
// alu_response_checker: receive side of the ALU test interface.
// It accepts {op_a, op_b, alu_out} vectors and checks each alu_out against op_a ^ op_b.
// It counts mismatches, records the index of the first mismatching vector, and compacts
// every accepted alu_out into a Galois MISR signature.
//
// Handshake: a vector transfers on a rising clk edge where in_valid && in_ready.
// in_ready is high only in RUN and does not depend on in_valid. The producer may hold
// in_valid low for any number of cycles without affecting results.
module alu_response_checker #(
    parameter int                 WIDTH     = 16,
    parameter int                 NUM_VEC   = 16,
    parameter logic [WIDTH-1:0]   MISR_POLY = 16'hB400,
    parameter logic [WIDTH-1:0]   MISR_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [WIDTH-1:0]  alu_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [7:0]        first_err_idx,
    output logic [WIDTH-1:0]  signature,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_VEC - 1);

    state_t           state;
    state_t           next_state;
    logic [7:0]       vec_cnt;
    logic             start_run;
    logic             accept;
    logic             mismatch;
    logic             last_vec;
    logic [WIDTH-1:0] misr_next;

    // Handshake and per-vector check terms
    always_comb begin
        start_run = start && (state != RUN);
        accept    = (state == RUN) && in_valid;
        mismatch  = (alu_out != (op_a ^ op_b));
        last_vec  = (vec_cnt == LAST_IDX);
        misr_next = {signature[WIDTH-2:0], 1'b0}
                    ^ (signature[WIDTH-1] ? MISR_POLY : '0)
                    ^ alu_out;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is honoured only outside RUN
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (accept && last_vec) next_state = DONE;
            DONE:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // Result registers: cleared on run start, updated once per accepted vector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
            signature     <= MISR_SEED;
            vec_cnt       <= 8'd0;
        end else if (start_run) begin
            err_count     <= 8'd0;
            first_err_idx <= 8'hFF;
            signature     <= MISR_SEED;
            vec_cnt       <= 8'd0;
        end else if (accept) begin
            if (mismatch && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (mismatch && (first_err_idx == 8'hFF)) begin
                first_err_idx <= vec_cnt;
            end
            signature <= misr_next;
            vec_cnt   <= vec_cnt + 8'd1;
        end
    end

    // Status outputs decoded directly from the state register
    always_comb begin
        in_ready  = (state == RUN);
        busy      = (state == RUN);
        done      = (state == DONE);
        pass      = (state == DONE) && (err_count == 8'd0);
        dbg_state = state;
    end

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed testbench for alu_response_checker.
// Instance u3 runs 3-vector checks; instance u255 covers error-count saturation.
module tb_alu_response_checker;

    logic clk;
    logic rst;

    // u3 signals
    logic        start, in_valid, in_ready, busy, done, pass;
    logic [15:0] op_a, op_b, alu_out, signature;
    logic [7:0]  err_count, first_err_idx;
    logic [1:0]  dbg_state;

    // u255 signals
    logic        s_start, s_in_valid, s_in_ready, s_busy, s_done, s_pass;
    logic [15:0] s_op_a, s_op_b, s_alu_out, s_signature;
    logic [7:0]  s_err_count, s_first_err_idx;
    logic [1:0]  s_dbg_state;

    int tests;
    int fails;

    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] vo [3];

    alu_response_checker #(.WIDTH(16), .NUM_VEC(3), .MISR_POLY(16'hB400), .MISR_SEED(16'hFFFF)) u3 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .alu_out(alu_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .signature(signature),
        .dbg_state(dbg_state)
    );

    alu_response_checker #(.WIDTH(16), .NUM_VEC(255), .MISR_POLY(16'hB400), .MISR_SEED(16'hFFFF)) u255 (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op_a(s_op_a), .op_b(s_op_b), .alu_out(s_alu_out), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_count(s_err_count), .first_err_idx(s_first_err_idx),
        .signature(s_signature), .dbg_state(s_dbg_state)
    );

    // Clock: 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks (u3) ----------------
    task automatic drive_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] o);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        alu_out  = o;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        tests++; if (done !== 1'b0 || pass !== 1'b0) begin fails++; $display("FAIL reset_done_pass got=%b%b exp=00", done, pass); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got=%h exp=00", err_count); end
        tests++; if (first_err_idx !== 8'hFF) begin fails++; $display("FAIL reset_first_err got=%h exp=FF", first_err_idx); end
        tests++; if (signature !== 16'hFFFF) begin fails++; $display("FAIL reset_signature got=%h exp=FFFF", signature); end
        tests++; if (s_err_count !== 8'd0 || s_signature !== 16'hFFFF) begin fails++; $display("FAIL reset_u255 got err=%h sig=%h exp err=00 sig=FFFF", s_err_count, s_signature); end
    endtask

    task automatic test_clean_run();
        start_pulse();
        for (int i = 0; i < 3; i++) drive_vec(va[i], vb[i], vo[i]);
        idle_cycle();
        tests++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL clean_status got done=%b busy=%b rdy=%b exp 1 0 0", done, busy, in_ready); end
        tests++; if (pass !== 1'b1) begin fails++; $display("FAIL clean_pass got=%b exp=1", pass); end
        tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL clean_err_count got=%h exp=00", err_count); end
        tests++; if (first_err_idx !== 8'hFF) begin fails++; $display("FAIL clean_first_err got=%h exp=FF", first_err_idx); end
        tests++; if (signature !== 16'h9B14) begin fails++; $display("FAIL clean_signature got=%h exp=9B14", signature); end
    endtask

    task automatic test_single_error();
        start_pulse();
        drive_vec(va[0], vb[0], vo[0]);
        drive_vec(va[1], vb[1], vo[1]);
        drive_vec(va[2], vb[2], 16'h00DF);
        idle_cycle();
        tests++; if (done !== 1'b1 || pass !== 1'b0) begin fails++; $display("FAIL err_done_pass got=%b%b exp=10", done, pass); end
        tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL err_err_count got=%h exp=01", err_count); end
        tests++; if (first_err_idx !== 8'h02) begin fails++; $display("FAIL err_first_err got=%h exp=02", first_err_idx); end
        tests++; if (signature !== 16'h9B15) begin fails++; $display("FAIL err_signature got=%h exp=9B15", signature); end
    endtask

    task automatic test_gapped();
        start_pulse();
        for (int i = 0; i < 3; i++) begin
            drive_vec(va[i], vb[i], vo[i]);
            if (i < 2) begin
                for (int g = 0; g < 2; g++) begin
                    idle_cycle();
                    tests++; if (in_ready !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL gap_in_ready vec=%0d gap=%0d got rdy=%b busy=%b exp 1 1", i, g, in_ready, busy); end
                end
            end
        end
        idle_cycle();
        tests++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0 || first_err_idx !== 8'hFF) begin fails++; $display("FAIL gap_results got done=%b pass=%b err=%h first=%h exp 1 1 00 FF", done, pass, err_count, first_err_idx); end
        tests++; if (signature !== 16'h9B14) begin fails++; $display("FAIL gap_signature got=%h exp=9B14", signature); end
    endtask

    task automatic test_reset_abort();
        start_pulse();
        drive_vec(va[0], vb[0], vo[0]);
        drive_vec(va[1], vb[1], 16'h0000);
        idle_cycle();
        tests++; if (err_count !== 8'd1 || busy !== 1'b1) begin fails++; $display("FAIL abort_pre got err=%h busy=%b exp 01 1", err_count, busy); end
        rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin fails++; $display("FAIL abort_status got busy=%b rdy=%b done=%b pass=%b exp 0000", busy, in_ready, done, pass); end
        tests++; if (err_count !== 8'd0 || first_err_idx !== 8'hFF || signature !== 16'hFFFF) begin fails++; $display("FAIL abort_results got err=%h first=%h sig=%h exp 00 FF FFFF", err_count, first_err_idx, signature); end
        @(negedge clk);
        rst = 1'b0;
        start_pulse();
        for (int i = 0; i < 3; i++) drive_vec(va[i], vb[i], vo[i]);
        idle_cycle();
        tests++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0 || first_err_idx !== 8'hFF || signature !== 16'h9B14) begin fails++; $display("FAIL abort_rerun got done=%b pass=%b err=%h first=%h sig=%h exp 1 1 00 FF 9B14", done, pass, err_count, first_err_idx, signature); end
    endtask

    task automatic test_ignored_inputs();
        // Return to IDLE, then offer wrong vectors that must be ignored
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) drive_vec(16'h1234, 16'h0F0F, 16'hAAAA);
        idle_cycle();
        tests++; if (dbg_state !== 2'd0 || err_count !== 8'd0 || signature !== 16'hFFFF || busy !== 1'b0) begin fails++; $display("FAIL idle_ignore got st=%0d err=%h sig=%h busy=%b exp 0 00 FFFF 0", dbg_state, err_count, signature, busy); end
        // start while busy must neither clear nor restart the run
        start_pulse();
        drive_vec(va[0], vb[0], vo[0]);
        drive_vec(va[1], vb[1], vo[1]);
        start = 1'b1;
        drive_vec(va[2], vb[2], vo[2]);
        idle_cycle();
        tests++; if (done !== 1'b1 || signature !== 16'h9B14 || err_count !== 8'd0) begin fails++; $display("FAIL busy_start got done=%b sig=%h err=%h exp 1 9B14 00", done, signature, err_count); end
        // vectors in DONE must be ignored
        drive_vec(16'h00FF, 16'h0001, 16'h5555);
        drive_vec(16'h0F00, 16'h0002, 16'h1111);
        idle_cycle();
        tests++; if (done !== 1'b1 || pass !== 1'b1 || signature !== 16'h9B14 || err_count !== 8'd0 || first_err_idx !== 8'hFF) begin fails++; $display("FAIL done_ignore got done=%b pass=%b sig=%h err=%h first=%h exp 1 1 9B14 00 FF", done, pass, signature, err_count, first_err_idx); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        s_start = 1'b1;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            s_start    = 1'b0;
            s_in_valid = 1'b1;
            s_op_a     = 16'(i);
            s_op_b     = 16'h0000;
            s_alu_out  = 16'(i) ^ 16'h0001;
            if (i == 200) begin
                tests++; if (s_err_count !== 8'd200 || s_busy !== 1'b1) begin fails++; $display("FAIL sat_mid got err=%h busy=%b exp C8 1", s_err_count, s_busy); end
            end
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        tests++; if (s_done !== 1'b1 || s_pass !== 1'b0) begin fails++; $display("FAIL sat_done got done=%b pass=%b exp 1 0", s_done, s_pass); end
        tests++; if (s_err_count !== 8'hFF) begin fails++; $display("FAIL sat_err_count got=%h exp=FF", s_err_count); end
        tests++; if (s_first_err_idx !== 8'h00) begin fails++; $display("FAIL sat_first_err got=%h exp=00", s_first_err_idx); end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        tests = 0;
        fails = 0;
        va[0] = 16'h0000; vb[0] = 16'h0001; vo[0] = 16'h0001;
        va[1] = 16'h000E; vb[1] = 16'h0015; vo[1] = 16'h001B;
        va[2] = 16'h0003; vb[2] = 16'h00DD; vo[2] = 16'h00DE;
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0; alu_out = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_op_a = '0; s_op_b = '0; s_alu_out = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_clean_run();
        test_single_error();
        test_gapped();
        test_reset_abort();
        test_ignored_inputs();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
